// File: rtl/tlb_walker.sv
// Two-level page-table walker: services TLB misses over a word-read port
// and fills the TLB or reports a fault / timeout exception code.
module tlb_walker #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_kmode,
  input  logic [11:0] req_pid,
  input  logic [19:0] req_vpn,
  input  logic [31:0] ptbr,
  input  logic        abort,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        tlb_we,
  output logic [31:0] tlb_key,
  output logic [31:0] tlb_data,
  output logic        done,
  output logic [7:0]  exc
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [7:0] EXC_OK   = 8'h00;
  localparam logic [7:0] EXC_KFLT = 8'h84;
  localparam logic [7:0] EXC_UFLT = 8'h85;
  localparam logic [7:0] EXC_TMO  = 8'h86;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_REQ,
    S_L1_WAIT,
    S_L2_REQ,
    S_L2_WAIT,
    S_FILL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_kmode;
  logic [11:0]   r_pid;
  logic [19:0]   r_vpn;
  logic [19:0]   r_ptbr;
  logic [19:0]   r_l2base;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_key;
  logic [31:0]   r_data;
  logic [7:0]    r_exc;

  logic w_accept;
  logic w_abort;
  logic w_wait;
  logic w_l1;
  logic w_l2;
  logic w_ack;
  logic w_tmo;
  logic w_pte_ok;
  logic w_unused;

  assign w_l1     = (r_state == S_L1_REQ) || (r_state == S_L1_WAIT);
  assign w_l2     = (r_state == S_L2_REQ) || (r_state == S_L2_WAIT);
  assign w_wait   = (r_state == S_L1_WAIT) || (r_state == S_L2_WAIT);
  assign w_accept = req_valid && (r_state == S_IDLE) && clk_en;
  assign w_abort  = abort && clk_en && (r_state != S_IDLE);
  assign w_ack    = w_wait && mem_ack;
  assign w_tmo    = w_wait && !mem_ack && (r_cnt == CW'(TIMEOUT - 1));
  assign w_pte_ok = mem_rdata[0];
  assign w_unused = ^mem_rdata[11:1];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (req_valid) w_next = S_L1_REQ;
      S_L1_REQ:  w_next = S_L1_WAIT;
      S_L1_WAIT: begin
        if (w_ack)      w_next = w_pte_ok ? S_L2_REQ : S_DONE;
        else if (w_tmo) w_next = S_DONE;
      end
      S_L2_REQ:  w_next = S_L2_WAIT;
      S_L2_WAIT: begin
        if (w_ack)      w_next = w_pte_ok ? S_FILL : S_DONE;
        else if (w_tmo) w_next = S_DONE;
      end
      S_FILL:    w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_kmode  <= 1'b0;
      r_pid    <= '0;
      r_vpn    <= '0;
      r_ptbr   <= '0;
      r_l2base <= '0;
      r_cnt    <= '0;
      r_key    <= '0;
      r_data   <= '0;
      r_exc    <= EXC_OK;
    end else if (clk_en) begin
      r_state <= w_next;
      r_cnt   <= w_wait ? r_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_kmode <= req_kmode;
        r_pid   <= req_pid;
        r_vpn   <= req_vpn;
        r_ptbr  <= ptbr[31:12];
        r_exc   <= EXC_OK;
      end
      // abort discards any data returned in the same cycle
      if (!w_abort) begin
        if (w_ack && w_pte_ok && r_state == S_L1_WAIT)
          r_l2base <= mem_rdata[31:12];
        if (w_ack && w_pte_ok && r_state == S_L2_WAIT) begin
          r_key  <= {r_pid, r_vpn};
          r_data <= {26'b0, mem_rdata[17:12]};
        end
        if (w_ack && !w_pte_ok)
          r_exc <= r_kmode ? EXC_KFLT : EXC_UFLT;
        else if (w_tmo)
          r_exc <= EXC_TMO;
      end
    end
  end

  always_comb begin
    mem_addr = '0;
    if (w_l1)      mem_addr = {r_ptbr, r_vpn[19:10], 2'b00};
    else if (w_l2) mem_addr = {r_l2base, r_vpn[9:0], 2'b00};
  end

  assign req_ready = (r_state == S_IDLE);
  assign mem_req   = w_l1 || w_l2;
  assign tlb_we    = (r_state == S_FILL) && !w_abort;
  assign done      = (r_state == S_DONE) && !w_abort;
  assign tlb_key   = r_key;
  assign tlb_data  = r_data;
  assign exc       = r_exc;

endmodule

// File: tb/tb_tlb_walker.sv
// Scoreboard bench for tlb_walker: expected memory reads, fills and
// completions are queued by stimulus and matched by an output monitor.
module tb_tlb_walker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_kmode = 1'b0;
  logic [11:0] req_pid = '0;
  logic [19:0] req_vpn = '0;
  logic [31:0] ptbr = '0;
  logic        abort = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        tlb_we;
  logic [31:0] tlb_key;
  logic [31:0] tlb_data;
  logic        done;
  logic [7:0]  exc;

  logic en_toggle = 1'b0;

  tlb_walker #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kmode(req_kmode), .req_pid(req_pid), .req_vpn(req_vpn),
    .ptbr(ptbr), .abort(abort),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .tlb_we(tlb_we), .tlb_key(tlb_key), .tlb_data(tlb_data),
    .done(done), .exc(exc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) clk_en = en_toggle ? ~clk_en : 1'b1;

  typedef struct {
    byte         k;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  ev_t q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic bound_fail(string nm);
    n_checks++;
    $display("FAIL %s: wait bound expired, got no event, required one", nm);
  endtask

  task automatic exp_ev(byte k, logic [31:0] a, logic [31:0] b);
    ev_t e;
    e.k = k; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  task automatic got(byte k, logic [31:0] a, logic [31:0] b);
    ev_t e;
    n_checks++;
    if (q.size() == 0) begin
      $display("FAIL unexpected_%c: got %h/%h required no event", k, a, b);
    end else begin
      e = q.pop_front();
      if (e.k == k && e.a === a && e.b === b) n_pass++;
      else $display("FAIL ev_%c: got %c %h/%h required %c %h/%h",
                    e.k, k, a, b, e.k, e.a, e.b);
    end
  endtask

  // monitor: event detection plus one-enabled-cycle pulse checks
  logic        p_req = 1'b0, p_we = 1'b0, p_done = 1'b0;
  logic [31:0] p_addr = '0;
  int          we_en = 0, done_en = 0;

  always @(posedge clk) begin
    if (rst_n && clk_en) begin
      if (tlb_we) we_en++;
      if (done) done_en++;
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      p_req = 1'b0; p_we = 1'b0; p_done = 1'b0;
      p_addr = '0; we_en = 0; done_en = 0;
    end else begin
      if (mem_req && (!p_req || mem_addr != p_addr))
        got("M", mem_addr, 32'h0);
      if (tlb_we && !p_we) got("W", tlb_key, tlb_data);
      if (done && !p_done) got("D", {24'h0, exc}, 32'h0);
      if (p_we && !tlb_we) begin
        chk("we_pulse_en_cycles", we_en, 1);
        we_en = 0;
      end
      if (p_done && !done) begin
        chk("done_pulse_en_cycles", done_en, 1);
        done_en = 0;
      end
      p_req = mem_req; p_addr = mem_addr;
      p_we = tlb_we; p_done = done;
    end
  end

  task automatic issue(logic km, logic [11:0] pid, logic [19:0] vpn,
                       logic [31:0] pt);
    int t;
    t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_kmode = km;
    req_pid = pid; req_vpn = vpn; ptbr = pt;
    do begin
      @(posedge clk);
      t++;
    end while (!(clk_en && req_ready) && t < 200);
    if (t >= 200) bound_fail("accept");
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic respond(logic [31:0] data);
    int t;
    t = 0;
    while (!mem_req && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      bound_fail("mem_req");
      return;
    end
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (!clk_en && t < 200);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = data;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (!clk_en && t < 200);
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) bound_fail("idle");
  endtask

  task automatic walk_ok();
    exp_ev("M", 32'h0001_0004, 32'h0);
    exp_ev("M", 32'h0002_000C, 32'h0);
    exp_ev("W", 32'h0050_0403, 32'h0000_002A);
    exp_ev("D", 32'h0, 32'h0);
    issue(1'b1, 12'h005, 20'h00403, 32'h0001_0000);
    respond(32'h0002_0001);
    respond(32'h0002_A001);
    wait_idle();
  endtask

  initial begin
    int cnt;
    #12;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_tlb_we", {31'h0, tlb_we}, 32'h0);
    chk("rst_tlb_key", tlb_key, 32'h0);
    chk("rst_tlb_data", tlb_data, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_exc", {24'h0, exc}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // nominal two-level walk with fill
    walk_ok();
    chk("walk_exc_held", {24'h0, exc}, 32'h0);

    // user L1 fault: no L2 access, no fill
    exp_ev("M", 32'h1234_5FFC, 32'h0);
    exp_ev("D", 32'h85, 32'h0);
    issue(1'b0, 12'h0AB, 20'hFFFFF, 32'h1234_5678);
    respond(32'h0000_0000);
    wait_idle();
    chk("ufault_exc_held", {24'h0, exc}, 32'h85);

    // kernel L2 fault
    exp_ev("M", 32'h1234_5FFC, 32'h0);
    exp_ev("M", 32'hABCD_EFFC, 32'h0);
    exp_ev("D", 32'h84, 32'h0);
    issue(1'b1, 12'h0AB, 20'hFFFFF, 32'h1234_5678);
    respond(32'hABCD_E001);
    respond(32'h0000_0FFE);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("kfault_exc_held", {24'h0, exc}, 32'h84);

    // timeout with no ack
    exp_ev("M", 32'h0003_000C, 32'h0);
    exp_ev("D", 32'h86, 32'h0);
    issue(1'b0, 12'h007, 20'h00C00, 32'h0003_0000);
    cnt = 0;
    while (mem_req && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", cnt, 5);
    wait_idle();
    chk("tmo_exc", {24'h0, exc}, 32'h86);

    // abort coincident with L2 ack, then a stray ack
    exp_ev("M", 32'h0001_0004, 32'h0);
    exp_ev("M", 32'h0002_000C, 32'h0);
    issue(1'b1, 12'h005, 20'h00403, 32'h0001_0000);
    respond(32'h0002_0001);
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h0002_A001; abort = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; abort = 1'b0;
    chk("abort_idle", {31'h0, req_ready}, 32'h1);
    chk("abort_mem_req", {31'h0, mem_req}, 32'h0);
    chk("abort_tlb_we", {31'h0, tlb_we}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    repeat (2) @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_idle", {31'h0, req_ready}, 32'h1);
    chk("stray_mem_req", {31'h0, mem_req}, 32'h0);

    // same walk with clk_en toggling
    en_toggle = 1'b1;
    walk_ok();
    en_toggle = 1'b0;
    repeat (3) @(negedge clk);

    // reset mid-walk in L1_WAIT
    exp_ev("M", 32'h0001_0004, 32'h0);
    issue(1'b1, 12'h005, 20'h00403, 32'h0001_0000);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("mrst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("mrst_mem_addr", mem_addr, 32'h0);
    chk("mrst_tlb_we", {31'h0, tlb_we}, 32'h0);
    chk("mrst_tlb_key", tlb_key, 32'h0);
    chk("mrst_tlb_data", tlb_data, 32'h0);
    chk("mrst_done", {31'h0, done}, 32'h0);
    chk("mrst_exc", {24'h0, exc}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    walk_ok();

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
